// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit adder/subtractor that works CHUNK bits per clock,
// keeping the inter-chunk carry in a register, with a start/busy/done handshake.
// Subtraction is done as A + ~B + ~cin, so cout reads as "no borrow" in sub mode.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  // A chunk size that does not tile the word would leave result bits unwritten.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gChunkCheck
    $error("multicycle_adder: CHUNK (%0d) must divide WIDTH (%0d) exactly", CHUNK, WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    chunkIdx_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum_d;
  logic             msbCarryIn_d;

  // Add the current slice of the latched operands plus the held carry.
  always_comb begin
    aChunk       = opA_q[int'(chunkIdx_q) * CHUNK +: CHUNK];
    bChunk       = opB_q[int'(chunkIdx_q) * CHUNK +: CHUNK];
    chunkSum_d   = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from the sum bit itself.
    msbCarryIn_d = aChunk[CHUNK-1] ^ bChunk[CHUNK-1] ^ chunkSum_d[CHUNK-1];
  end

  // Control FSM and datapath registers; reset clears everything, even mid-run.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      chunkIdx_q <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            opA_q      <= a_i;
            opB_q      <= sub_i ? ~b_i : b_i;
            carry_q    <= sub_i ? ~cin_i : cin_i;
            chunkIdx_q <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[int'(chunkIdx_q) * CHUNK +: CHUNK] <= chunkSum_d[CHUNK-1:0];
          carry_q    <= chunkSum_d[CHUNK];
          chunkIdx_q <= chunkIdx_q + CW'(1);
          if (chunkIdx_q == LAST_CHUNK) begin
            cout_q  <= chunkSum_d[CHUNK];
            ovf_q   <= msbCarryIn_d ^ chunkSum_d[CHUNK];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: drives three adders (CHUNK 1, 4, 16 at WIDTH 16) with the
// same inputs and compares each against a per-operation arithmetic model.
module tb_multicycle_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sub;
  logic cin;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic busy [3];
  logic done [3];
  logic cout [3];
  logic ovf  [3];
  logic [W-1:0] s [3];

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(W), .CHUNK(1)) dutC1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sub_i(sub),
    .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[0]), .done_o(done[0]), .s_o(s[0]), .cout_o(cout[0]), .ovf_o(ovf[0])
  );

  multicycle_adder #(.WIDTH(W), .CHUNK(4)) dutC4 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sub_i(sub),
    .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[1]), .done_o(done[1]), .s_o(s[1]), .cout_o(cout[1]), .ovf_o(ovf[1])
  );

  multicycle_adder #(.WIDTH(W), .CHUNK(16)) dutC16 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sub_i(sub),
    .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy[2]), .done_o(done[2]), .s_o(s[2]), .cout_o(cout[2]), .ovf_o(ovf[2])
  );

  function automatic int nchunkOf(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic int chunkOf(input int d);
    return W / nchunkOf(d);
  endfunction

  // Result of one operation from plain integer arithmetic: {ovf, cout, S}.
  function automatic logic [17:0] opModel(input logic op, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c);
    int ua;
    int sa;
    logic co;
    logic ov;
    if (!op) begin
      ua = int'(x) + int'(y) + int'(c);
      sa = int'($signed(x)) + int'($signed(y)) + int'(c);
      co = (ua > 65535);
    end else begin
      ua = int'(x) - int'(y) - int'(c);
      sa = int'($signed(x)) - int'($signed(y)) - int'(c);
      co = (ua >= 0);
    end
    ov = (sa > 32767) || (sa < -32768);
    return {ov, co, ua[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] modelS    [3] = '{default: '0};
  logic         modelCout [3] = '{default: 1'b0};
  logic         modelOvf  [3] = '{default: 1'b0};
  logic         modelBusy [3] = '{default: 1'b0};
  logic         modelDone [3] = '{default: 1'b0};
  logic [17:0]  pendRes   [3] = '{default: '0};
  int           runLeft   [3] = '{default: 0};

  // Model: an accepted op produces its result NCHUNK edges later, then a done pulse.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        modelS[d] = '0; modelCout[d] = 1'b0; modelOvf[d] = 1'b0;
        modelBusy[d] = 1'b0; modelDone[d] = 1'b0; runLeft[d] = 0;
      end else if (start && !modelBusy[d]) begin
        pendRes[d]   = opModel(sub, a, b, cin);
        modelBusy[d] = 1'b1;
        modelDone[d] = 1'b0;
        modelS[d]    = '0;
        runLeft[d]   = nchunkOf(d);
      end else if (modelBusy[d]) begin
        runLeft[d]--;
        if (runLeft[d] == 0) begin
          modelBusy[d] = 1'b0;
          modelDone[d] = 1'b1;
          {modelOvf[d], modelCout[d], modelS[d]} = pendRes[d];
        end
      end else begin
        modelDone[d] = 1'b0;
      end
    end
  end

  // Compare every DUT to the model each cycle; results only when not running.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("busy C%0d", chunkOf(d)), 32'(busy[d]), 32'(modelBusy[d]));
        checkOutput($sformatf("done C%0d", chunkOf(d)), 32'(done[d]), 32'(modelDone[d]));
        if (!modelBusy[d]) begin
          checkOutput($sformatf("S C%0d", chunkOf(d)), 32'(s[d]), 32'(modelS[d]));
          checkOutput($sformatf("cout C%0d", chunkOf(d)), 32'(cout[d]), 32'(modelCout[d]));
          checkOutput($sformatf("ovf C%0d", chunkOf(d)), 32'(ovf[d]), 32'(modelOvf[d]));
        end
      end
    end
  end

  // One op with a start pulse; checks latency per DUT and the literal result.
  task automatic applyStimulus(input logic op, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input logic cIn, input logic [W-1:0] expS, input logic expC,
                               input logic expO);
    int seen [3];
    int n;
    seen = '{0, 0, 0};
    sub = op; a = aIn; b = bIn; cin = cIn; start = 1'b1;
    n = 0;
    while (seen[0] == 0 && n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      sub = ~op; a = ~aIn; b = bIn ^ 16'h5A5A; cin = ~cIn;
      for (int d = 0; d < 3; d++) begin
        if (done[d] && seen[d] == 0) seen[d] = n;
      end
    end
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("latency C%0d", chunkOf(d)), 32'(seen[d]), 32'(nchunkOf(d) + 1));
      checkOutput($sformatf("lit S C%0d", chunkOf(d)), 32'(s[d]), 32'(expS));
      checkOutput($sformatf("lit cout C%0d", chunkOf(d)), 32'(cout[d]), 32'(expC));
      checkOutput($sformatf("lit ovf C%0d", chunkOf(d)), 32'(ovf[d]), 32'(expO));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset outputs C%0d", chunkOf(d)),
                  32'({busy[d], done[d], cout[d], ovf[d], s[d]}), 32'd0);
    end
    reset = 1'b0;

    checkOutput("model add", 32'(opModel(1'b0, 16'h1234, 16'h4321, 1'b0)), 32'h05555);
    checkOutput("model carry chain", 32'(opModel(1'b0, 16'hFFFF, 16'h0001, 1'b0)), 32'h10000);
    checkOutput("model sub overflow", 32'(opModel(1'b1, 16'h8000, 16'h0001, 1'b0)), 32'h37FFF);
    checkOutput("model sub borrow", 32'(opModel(1'b1, 16'h0005, 16'h0007, 1'b0)), 32'h0FFFE);

    applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Mid-run reset: cout is still 1 from the previous op, S partly built.
    sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("midrun reset C%0d", chunkOf(d)),
                  32'({busy[d], done[d], cout[d], ovf[d], s[d]}), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Handshake: start held high; the 4-bit DUT must not restart before DONE.
    @(negedge clk);
    sub = 1'b0; a = 16'h0101; b = 16'h0202; cin = 1'b1; start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 3) checkOutput("hold busy C4", 32'(busy[1]), 32'd1);
      if (n == 5) checkOutput("hold done C4", 32'({busy[1], done[1], s[1]}), 32'h10304);
      if (n == 6) checkOutput("restart busy C4", 32'({busy[1], done[1]}), 32'b10);
      if (n == 10) checkOutput("second done C4", 32'(done[1]), 32'd1);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Random ops; inputs keep changing while the DUTs are busy.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        2: a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'hFFFF;
        1: b = 16'h0001;
        2: b = 16'h0000;
        default: b = 16'($urandom);
      endcase
      sub = 1'($urandom); cin = 1'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        if (!busy[0] && !busy[1] && !busy[2]) break;
      end
      if (busy[0] || busy[1] || busy[2]) begin
        checkOutput("random drain timeout", 32'({busy[0], busy[1], busy[2]}), 32'd0);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
